// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift/rotate unit: op encodings,
// FSM states and the shift-amount width derivation.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SHR  = 3'd0,
        OP_SHRA = 3'd1,
        OP_SHL  = 3'd2,
        OP_ROR  = 3'd3,
        OP_ROL  = 3'd4
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int shw_of(input int width);
        return $clog2(width);
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step mover: shifts or rotates data by k positions
// according to op; illegal ops pass data through unchanged.
module shift_step
    import shift_pkg::*;
#(
    parameter int  WIDTH = 32,
    localparam int SHW   = shw_of(WIDTH)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   k,
    output logic [WIDTH-1:0] moved
);

    logic [2*WIDTH-1:0] doubled;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        doubled = {data, data};
        moved   = data;
        case (op)
            OP_SHR:  moved = data >> k;
            OP_SHRA: moved = $unsigned($signed(data) >>> k);
            OP_SHL:  moved = data << k;
            // Rotates read a WIDTH window out of the doubled word.
            OP_ROR:  moved = WIDTH'(doubled >> k);
            OP_ROL:  moved = WIDTH'(doubled >> (WIDTH - int'(k)));
            default: moved = data;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter/rotator: captures a request, moves up to STEP bit
// positions per cycle, then holds the result until the consumer accepts it.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  STEP  = 4,
    localparam int SHW   = shw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [SHW-1:0]   shamt,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] moved;
    logic [SHW-1:0]   rem_q;
    logic [SHW-1:0]   step_k;
    logic [SHW-1:0]   rem_next;
    logic             err_q;

    // Remaining never exceeds WIDTH-1, so the STEP branch is only taken
    // when STEP itself fits in SHW bits.
    always_comb begin
        step_k = rem_q;
        if (int'(rem_q) >= STEP) begin
            step_k = SHW'(STEP);
        end
        rem_next = rem_q - step_k;
    end

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op   (op_q),
        .data (work_q),
        .k    (step_k),
        .moved(moved)
    );

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        out_valid = 1'b0;
        result    = '0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (shamt != '0 && op_is_legal(op)) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (rem_next == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                result    = work_q;
                err       = err_q;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the datapath registers are reset too, because a reset mid-operation
    // must leave no stale working value or count behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            work_q <= '0;
            rem_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        work_q <= operand;
                        rem_q  <= shamt;
                        err_q  <= !op_is_legal(op);
                    end
                end
                ST_SHIFT: begin
                    work_q <= moved;
                    rem_q  <= rem_next;
                end
                default: ;
            endcase
        end
    end

endmodule
